// File: rtl/sva_mon_pkg.sv
// rtl/sva_mon_pkg.sv - shared check ids, sizes and popcount helper for the sampled-value monitor
package sva_mon_pkg;

  typedef enum logic [2:0] {
    CHK_ROSE_A   = 3'd0,
    CHK_FELL_B   = 3'd1,
    CHK_STABLE_C = 3'd2,
    CHK_ONES_D   = 3'd3,
    CHK_PAST_D   = 3'd4
  } chk_id_e;

  localparam int NUM_CHK = 5;
  localparam int MAX_DW  = 64;

  function automatic int unsigned popcount(input logic [MAX_DW-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_DW; i++) n += {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sva_sample_monitor.sv
// rtl/sva_sample_monitor.sv - synthesizable $rose/$fell/$stable/$countones/$past checks with counters
module sva_sample_monitor
  import sva_mon_pkg::*;
#(
  parameter int DW         = 8,
  parameter int PAST_DEPTH = 2,
  parameter int CW         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr_cnt,
  input  logic                     a,
  input  logic                     b,
  input  logic                     c,
  input  logic [DW-1:0]            d,
  input  logic [$clog2(DW+1)-1:0]  ones_thresh,
  input  logic [DW-1:0]            past_ref,
  output logic                     chk_valid,
  output logic [NUM_CHK-1:0]       res,
  output logic                     past_valid,
  output logic [NUM_CHK*CW-1:0]    pass_cnt,
  output logic [NUM_CHK*CW-1:0]    fail_cnt
);

  localparam int OW = $clog2(DW+1);
  localparam int WW = $clog2(PAST_DEPTH+1);

  logic               prev_a, prev_b, prev_c;
  logic [DW-1:0]      d_hist [PAST_DEPTH];
  logic [WW-1:0]      warm;
  logic               warm_done;
  logic [OW-1:0]      ones;
  logic [NUM_CHK-1:0] res_next;
  logic [NUM_CHK-1:0] counted, inc_pass, inc_fail;

  always_comb begin
    ones      = OW'(popcount(MAX_DW'(d)));
    warm_done = (warm == WW'(PAST_DEPTH));
    res_next  = '0;
    res_next[CHK_ROSE_A]   = ~prev_a & a;
    res_next[CHK_FELL_B]   = prev_b & ~b;
    res_next[CHK_STABLE_C] = (c == prev_c);
    res_next[CHK_ONES_D]   = (ones > ones_thresh);
    // Until the history is full the $past check is vacuous and reports pass.
    res_next[CHK_PAST_D]   = ~warm_done | (d_hist[PAST_DEPTH-1] != past_ref);
  end

  // "Previous" means the previous qualified sample, so all history only moves when en is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      res        <= '0;
      chk_valid  <= 1'b0;
      past_valid <= 1'b0;
      prev_a     <= 1'b0;
      prev_b     <= 1'b0;
      prev_c     <= 1'b0;
      warm       <= '0;
      for (int i = 0; i < PAST_DEPTH; i++) d_hist[i] <= '0;
    end else if (en) begin
      res        <= res_next;
      chk_valid  <= 1'b1;
      past_valid <= warm_done;
      prev_a     <= a;
      prev_b     <= b;
      prev_c     <= c;
      d_hist[0]  <= d;
      for (int i = 1; i < PAST_DEPTH; i++) d_hist[i] <= d_hist[i-1];
      if (!warm_done) warm <= warm + WW'(1);
    end else begin
      chk_valid <= 1'b0;
    end
  end

  // The $past check only counts once it is non-vacuous; it is the top check id.
  assign counted  = {past_valid, {(NUM_CHK-1){1'b1}}};
  assign inc_pass = {NUM_CHK{chk_valid}} & counted & res;
  assign inc_fail = {NUM_CHK{chk_valid}} & counted & ~res;

  for (genvar i = 0; i < NUM_CHK; i++) begin : g_cnt
    sat_counter #(.CW(CW)) u_pass (
      .clk (clk),
      .rst (rst),
      .clr (clr_cnt),
      .inc (inc_pass[i]),
      .cnt (pass_cnt[i*CW +: CW])
    );
    sat_counter #(.CW(CW)) u_fail (
      .clk (clk),
      .rst (rst),
      .clr (clr_cnt),
      .inc (inc_fail[i]),
      .cnt (fail_cnt[i*CW +: CW])
    );
  end

endmodule

// File: tb/tb_sva_sample_monitor.sv
// tb/tb_sva_sample_monitor.sv - randomized self-checking bench for sva_sample_monitor
module tb_sva_sample_monitor;

  localparam int DW = 8;
  localparam int PD = 2;
  localparam int CW = 4;
  localparam int NC = 5;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          clr_cnt = 1'b0;
  logic          a = 1'b0, b = 1'b0, c = 1'b0;
  logic [DW-1:0] d = '0;
  logic [3:0]    ones_thresh = 4'd2;
  logic [DW-1:0] past_ref = 8'h03;
  logic          chk_valid;
  logic [NC-1:0] res;
  logic          past_valid;
  logic [NC*CW-1:0] pass_cnt, fail_cnt;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic          a, b, c;
    logic [DW-1:0] d;
  } samp_t;

  samp_t         hist[$];
  logic [NC-1:0] m_res = '0;
  logic          m_cv = 1'b0;
  logic          m_pv = 1'b0;
  int            m_pass[NC];
  int            m_fail[NC];

  sva_sample_monitor #(.DW(DW), .PAST_DEPTH(PD), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .clr_cnt     (clr_cnt),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .ones_thresh (ones_thresh),
    .past_ref    (past_ref),
    .chk_valid   (chk_valid),
    .res         (res),
    .past_valid  (past_valid),
    .pass_cnt    (pass_cnt),
    .fail_cnt    (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Counters count the result of the previous sample; a new sample is judged against the stored history.
  task automatic model_edge();
    samp_t prev, cur;
    logic [NC-1:0] r;
    if (rst) begin
      hist.delete();
      m_res = '0; m_cv = 1'b0; m_pv = 1'b0;
      for (int i = 0; i < NC; i++) begin m_pass[i] = 0; m_fail[i] = 0; end
      return;
    end
    if (clr_cnt) begin
      for (int i = 0; i < NC; i++) begin m_pass[i] = 0; m_fail[i] = 0; end
    end else if (m_cv) begin
      for (int i = 0; i < NC; i++) begin
        if (i < NC-1 || m_pv) begin
          if (m_res[i]) m_pass[i] = (m_pass[i] < SAT) ? m_pass[i] + 1 : SAT;
          else          m_fail[i] = (m_fail[i] < SAT) ? m_fail[i] + 1 : SAT;
        end
      end
    end
    if (en) begin
      if (hist.size() > 0) prev = hist[$];
      else begin prev.a = 0; prev.b = 0; prev.c = 0; prev.d = '0; end
      r[0] = !prev.a && a;
      r[1] = prev.b && !b;
      r[2] = (c == prev.c);
      r[3] = $countones(d) > int'(ones_thresh);
      m_pv = (hist.size() >= PD);
      r[4] = m_pv ? (hist[hist.size()-PD].d != past_ref) : 1'b1;
      cur.a = a; cur.b = b; cur.c = c; cur.d = d;
      hist.push_back(cur);
      m_res = r;
      m_cv = 1'b1;
    end else begin
      m_cv = 1'b0;
    end
  endtask

  task automatic step(input logic en_i, input logic a_i, input logic b_i, input logic c_i,
                      input logic [DW-1:0] d_i, input logic clr_i, input logic rst_i);
    logic [NC*CW-1:0] ep, ef;
    en = en_i; a = a_i; b = b_i; c = c_i; d = d_i; clr_cnt = clr_i; rst = rst_i;
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < NC; i++) begin
      ep[i*CW +: CW] = CW'(m_pass[i]);
      ef[i*CW +: CW] = CW'(m_fail[i]);
    end
    check("chk_valid", 64'(chk_valid), 64'(m_cv));
    check("res", 64'(res), 64'(m_res));
    check("past_valid", 64'(past_valid), 64'(m_pv));
    check("pass_cnt", 64'(pass_cnt), 64'(ep));
    check("fail_cnt", 64'(fail_cnt), 64'(ef));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, a, b, c, d, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [DW-1:0] dseq [5];
    logic          aseq [5];
    #2;
    // Reset, then idle with en low
    do_reset();
    check("reset_all", 64'({chk_valid, res, past_valid, pass_cnt, fail_cnt}), 64'd0);
    idle(5);
    check("idle_all", 64'({chk_valid, res, past_valid, pass_cnt, fail_cnt}), 64'd0);

    // $rose on a
    aseq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) step(1'b1, aseq[i], 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(2);
    check("rose_pass", 64'(pass_cnt[0 +: CW]), 64'd1);
    check("rose_fail", 64'(fail_cnt[0 +: CW]), 64'd4);

    // $past(d,2) and countones
    do_reset();
    dseq = '{8'hDC, 8'hDC, 8'h03, 8'hDC, 8'hDC};
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, dseq[i], 1'b0, 1'b0);
    idle(2);
    check("past_pass", 64'(pass_cnt[4*CW +: CW]), 64'd2);
    check("past_fail", 64'(fail_cnt[4*CW +: CW]), 64'd1);
    check("ones_fail", 64'(fail_cnt[3*CW +: CW]), 64'd1);

    // en gap: previous sample survives idle cycles
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("gap_cv_low", 64'(chk_valid), 64'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("gap_rose", 64'(res[0]), 64'd1);

    // Saturation on $fell
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, ((i % 2) == 0), 1'b0, 8'h00, 1'b0, 1'b0);
    idle(2);
    check("fell_sat_pass", 64'(pass_cnt[1*CW +: CW]), 64'(SAT));
    check("fell_sat_fail", 64'(fail_cnt[1*CW +: CW]), 64'(SAT));

    // clr_cnt on a chk_valid edge, then reset with 03 in history
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0);
    check("clr_pass", 64'(pass_cnt), 64'd0);
    check("clr_fail", 64'(fail_cnt), 64'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'hDC, 1'b0, 1'b0);
      check("rst_pv_low", 64'(past_valid), 64'd0);
    end
    idle(2);
    check("rst_no_c4", 64'(fail_cnt[4*CW +: CW]), 64'd0);

    // Randomized traffic with occasional clears, resets and threshold changes
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) ones_thresh = 4'($urandom_range(0, 8));
      if ($urandom_range(0, 19) == 0) past_ref = 8'($urandom);
      step(($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0) ? past_ref : 8'($urandom),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 79) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
